// File: rtl/uart_mmio_master.sv
// Bus initiator for a memory-mapped UART register block.
// It polls the status register, drains received bytes and writes buffered transmit bytes.
module uart_mmio_master #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] CTRL_INIT  = 32'h1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            send_byte,
    input  logic                  send_valid,
    output logic                  send_ready,
    output logic [7:0]            recv_byte,
    output logic                  recv_valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_enable,
    output logic                  read_enable,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] A_DATA   = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(8'h08);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_POLL_REQ,
        S_POLL_WAIT,
        S_RX_REQ,
        S_RX_WAIT,
        S_TX_WRITE
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         recv_byte_q, recv_byte_d;
    logic               recv_valid_q, recv_valid_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [7:0]         head;
    logic               unused_rd_hi;

    assign full         = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign push         = send_valid && !full;
    assign pop          = (state_q == S_TX_WRITE);
    assign head         = mem_q[rd_ptr_q];
    assign unused_rd_hi = ^read_data[DATA_WIDTH-1:8];

    assign send_ready   = !full;
    assign recv_byte    = recv_byte_q;
    assign recv_valid   = recv_valid_q;
    assign busy         = !reset && ((state_q != S_IDLE) || !empty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_INIT;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            recv_byte_q  <= '0;
            recv_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            recv_byte_q  <= recv_byte_d;
            recv_valid_q <= recv_valid_d;
        end
    end

    // Storage is pure data; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= send_byte;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        recv_byte_d  = recv_byte_q;
        recv_valid_d = 1'b0;
        case (state_q)
            S_INIT:      state_d = S_IDLE;
            S_IDLE:      state_d = S_POLL_REQ;
            S_POLL_REQ:  state_d = S_POLL_WAIT;
            S_POLL_WAIT: begin
                // A pending receive always wins over a transmit.
                if (read_data[0]) begin
                    state_d = S_RX_REQ;
                end else if (!read_data[1] && !empty) begin
                    state_d = S_TX_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RX_REQ:    state_d = S_RX_WAIT;
            S_RX_WAIT: begin
                recv_byte_d  = read_data[7:0];
                recv_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_TX_WRITE:  state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Bus outputs come only from registered state; reset kills strobes at once.
    always_comb begin
        addr         = '0;
        write_data   = '0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_INIT: begin
                    write_enable = 1'b1;
                    addr         = A_CTRL;
                    write_data   = DATA_WIDTH'(CTRL_INIT);
                end
                S_POLL_REQ: begin
                    read_enable  = 1'b1;
                    addr         = A_STATUS;
                end
                S_RX_REQ: begin
                    read_enable  = 1'b1;
                    addr         = A_DATA;
                end
                S_TX_WRITE: begin
                    write_enable = 1'b1;
                    addr         = A_DATA;
                    write_data   = DATA_WIDTH'(head);
                end
                default: begin
                    addr         = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_master.sv
// Directed bench for uart_mmio_master with a small UART register-block responder.
module tb_uart_mmio_master;

    logic        clk;
    logic        reset;
    logic [7:0]  send_byte;
    logic        send_valid;
    logic        send_ready;
    logic [7:0]  recv_byte;
    logic        recv_valid;
    logic [7:0]  addr;
    logic [31:0] write_data;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] read_data;
    logic        busy;

    uart_mmio_master #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .FIFO_DEPTH(4),
        .CTRL_INIT(32'h1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .send_byte(send_byte),
        .send_valid(send_valid),
        .send_ready(send_ready),
        .recv_byte(recv_byte),
        .recv_valid(recv_valid),
        .addr(addr),
        .write_data(write_data),
        .write_enable(write_enable),
        .read_enable(read_enable),
        .read_data(read_data),
        .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] status_val = 32'h0;
    logic [31:0] rx_val     = 32'h0;
    logic        rd_pend    = 1'b0;
    logic [7:0]  rd_addr    = 8'h0;

    logic [31:0] wr_q [$];
    int          rd4_count  = 0;
    int          ctrl_count = 0;
    int          viol       = 0;
    logic        prev_we    = 1'b0;
    logic        prev_re    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register block: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        rd_pend = read_enable;
        rd_addr = addr;
    end

    always @(negedge clk) begin
        if (rd_pend && rd_addr == 8'h00)      read_data = status_val;
        else if (rd_pend && rd_addr == 8'h04) read_data = rx_val;
        else                                  read_data = 32'h0;
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_we = 1'b0;
            prev_re = 1'b0;
        end else begin
            if (write_enable && read_enable) viol++;
            if ((write_enable && prev_we) || (read_enable && prev_re)) viol++;
            if (!write_enable && !read_enable && (addr != 8'h0 || write_data != 32'h0)) viol++;
            if (write_enable && addr == 8'h04) wr_q.push_back(write_data);
            if (write_enable && addr == 8'h08) ctrl_count++;
            if (read_enable && addr == 8'h04) rd4_count++;
            prev_we = write_enable;
            prev_re = read_enable;
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit done;
        done       = 1'b0;
        send_byte  = b;
        send_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (send_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        n_checks++;
        if (!done) $display("FAIL push_accept: byte %h not accepted, required acceptance within 200 cycles", b);
        else n_pass++;
    endtask

    task automatic wait_writes(input int n, input string name);
        int i;
        for (i = 0; i < 200 && wr_q.size() < n; i++) cycles(1);
        n_checks++;
        if (wr_q.size() < n) $display("FAIL %s: saw %0d data writes, required %0d", name, wr_q.size(), n);
        else n_pass++;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        send_valid = 1'b0;
        send_byte  = 8'h0;
        status_val = 32'h0;
        cycles(3);
        @(negedge clk);
        n_checks++; if (write_enable !== 1'b0) $display("FAIL rst_we: got %b required 0", write_enable); else n_pass++;
        n_checks++; if (read_enable !== 1'b0) $display("FAIL rst_re: got %b required 0", read_enable); else n_pass++;
        n_checks++; if (addr !== 8'h0) $display("FAIL rst_addr: got %h required 00", addr); else n_pass++;
        n_checks++; if (write_data !== 32'h0) $display("FAIL rst_wdata: got %h required 0", write_data); else n_pass++;
        n_checks++; if (recv_byte !== 8'h0) $display("FAIL rst_rbyte: got %h required 00", recv_byte); else n_pass++;
        n_checks++; if (recv_valid !== 1'b0) $display("FAIL rst_rvalid: got %b required 0", recv_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else n_pass++;
        n_checks++; if (send_ready !== 1'b1) $display("FAIL rst_ready: got %b required 1", send_ready); else n_pass++;
    endtask

    task automatic test_init_poll;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (write_enable !== 1'b1 || addr !== 8'h08 || write_data !== 32'h1)
            $display("FAIL init_write: got we=%b addr=%h data=%h required we=1 addr=08 data=00000001", write_enable, addr, write_data);
        else n_pass++;
        cycles(1);
        n_checks++;
        if (write_enable !== 1'b0 || read_enable !== 1'b0)
            $display("FAIL idle_cycle1: got we=%b re=%b required 0 0", write_enable, read_enable);
        else n_pass++;
        cycles(1);
        n_checks++;
        if (read_enable !== 1'b1 || addr !== 8'h00 || write_enable !== 1'b0)
            $display("FAIL poll_cycle2: got re=%b addr=%h required re=1 addr=00", read_enable, addr);
        else n_pass++;
        cycles(2);
        n_checks++;
        if (read_enable !== 1'b0 || busy !== 1'b0)
            $display("FAIL idle_cycle4: got re=%b busy=%b required 0 0", read_enable, busy);
        else n_pass++;
        cycles(1);
        n_checks++;
        if (read_enable !== 1'b1 || addr !== 8'h00)
            $display("FAIL poll_cycle5: got re=%b addr=%h required re=1 addr=00", read_enable, addr);
        else n_pass++;
        n_checks++;
        if (ctrl_count !== 1) $display("FAIL ctrl_once: got %0d control writes required 1", ctrl_count); else n_pass++;
    endtask

    task automatic test_single_tx;
        bit seen_idle;
        wr_q.delete();
        status_val = 32'h0;
        push_byte(8'h41);
        send_valid = 1'b0;
        wait_writes(1, "tx_single_wait");
        cycles(10);
        n_checks++;
        if (wr_q.size() !== 1) $display("FAIL tx_single_count: got %0d writes required 1", wr_q.size()); else n_pass++;
        n_checks++;
        if (wr_q.size() == 0 || wr_q[0] !== 32'h00000041)
            $display("FAIL tx_single_data: got %h required 00000041", (wr_q.size() > 0) ? wr_q[0] : 32'hx);
        else n_pass++;
        seen_idle = 1'b0;
        for (int i = 0; i < 6 && !seen_idle; i++) begin
            @(negedge clk);
            if (busy === 1'b0) seen_idle = 1'b1;
        end
        n_checks++;
        if (!seen_idle) $display("FAIL tx_single_busy: busy stayed 1, required 0 in IDLE"); else n_pass++;
        cycles(1);
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [5];
        exp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        wr_q.delete();
        status_val = 32'h2;
        push_byte(8'h10);
        push_byte(8'h20);
        push_byte(8'h30);
        push_byte(8'h40);
        n_checks++;
        if (send_ready !== 1'b0) $display("FAIL b2b_full: got send_ready=%b required 0", send_ready); else n_pass++;
        status_val = 32'h0;
        push_byte(8'h50);
        send_valid = 1'b0;
        wait_writes(5, "b2b_wait");
        cycles(20);
        n_checks++;
        if (wr_q.size() !== 5) $display("FAIL b2b_count: got %0d writes required 5", wr_q.size()); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= wr_q.size() || wr_q[i] !== {24'h0, exp[i]})
                $display("FAIL b2b_order%0d: got %h required %h", i, (i < wr_q.size()) ? wr_q[i] : 32'hx, {24'h0, exp[i]});
            else n_pass++;
        end
    endtask

    task automatic test_rx_priority;
        bit seen;
        wr_q.delete();
        rd4_count  = 0;
        status_val = 32'h2;
        push_byte(8'h55);
        send_valid = 1'b0;
        rx_val     = 32'h000000A5;
        status_val = 32'h3;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (recv_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL rx_pulse_wait: recv_valid never rose, required one pulse"); else n_pass++;
        n_checks++;
        if (recv_byte !== 8'hA5) $display("FAIL rx_byte: got %h required a5", recv_byte); else n_pass++;
        n_checks++;
        if (wr_q.size() !== 0) $display("FAIL rx_before_tx: got %0d writes required 0", wr_q.size()); else n_pass++;
        @(posedge clk);
        #1;
        status_val = 32'h2;
        @(negedge clk);
        n_checks++;
        if (recv_valid !== 1'b0) $display("FAIL rx_pulse_len: got recv_valid=%b required 0", recv_valid); else n_pass++;
        cycles(12);
        n_checks++;
        if (wr_q.size() !== 0) $display("FAIL rx_tx_held: got %0d writes required 0", wr_q.size()); else n_pass++;
        n_checks++;
        if (rd4_count !== 1) $display("FAIL rx_read_count: got %0d data reads required 1", rd4_count); else n_pass++;
        status_val = 32'h0;
        wait_writes(1, "rx_tx_wait");
        n_checks++;
        if (wr_q.size() == 0 || wr_q[0] !== 32'h00000055)
            $display("FAIL rx_tx_data: got %h required 00000055", (wr_q.size() > 0) ? wr_q[0] : 32'hx);
        else n_pass++;
        n_checks++;
        if (recv_byte !== 8'hA5) $display("FAIL rx_hold: got %h required a5", recv_byte); else n_pass++;
        cycles(4);
    endtask

    task automatic test_tx_busy_hold;
        wr_q.delete();
        status_val = 32'h2;
        push_byte(8'h77);
        send_valid = 1'b0;
        cycles(15);
        n_checks++;
        if (wr_q.size() !== 0) $display("FAIL busy_hold: got %0d writes required 0", wr_q.size()); else n_pass++;
        status_val = 32'h0;
        wait_writes(1, "busy_release_wait");
        n_checks++;
        if (wr_q.size() == 0 || wr_q[0] !== 32'h00000077)
            $display("FAIL busy_release_data: got %h required 00000077", (wr_q.size() > 0) ? wr_q[0] : 32'hx);
        else n_pass++;
        cycles(4);
    endtask

    task automatic test_reset_mid;
        bit found;
        status_val = 32'h2;
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        send_valid = 1'b0;
        status_val = 32'h0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (write_enable === 1'b1 && addr === 8'h04) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL mid_tx_wait: no data write seen, required one within 20 cycles"); else n_pass++;
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (write_enable !== 1'b0) $display("FAIL mid_we_drop: got %b required 0", write_enable); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL mid_busy: got %b required 0", busy); else n_pass++;
        wr_q.delete();
        ctrl_count = 0;
        cycles(2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (send_ready !== 1'b1) $display("FAIL mid_ready: got %b required 1", send_ready); else n_pass++;
        cycles(40);
        n_checks++;
        if (wr_q.size() !== 0) $display("FAIL mid_stale: got %0d stale writes required 0", wr_q.size()); else n_pass++;
        n_checks++;
        if (ctrl_count !== 1) $display("FAIL mid_reinit: got %0d control writes required 1", ctrl_count); else n_pass++;
        n_checks++;
        if (viol !== 0) $display("FAIL protocol: got %0d strobe violations required 0", viol); else n_pass++;
    endtask

    initial begin
        read_data = 32'h0;
        test_reset();
        test_init_poll();
        test_single_tx();
        test_back_to_back();
        test_rx_priority();
        test_tx_busy_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
